lzrw1_sequencer: RTL
====================

LZRW1_SEQUENCER -- requirements
Module: lzrw1_sequencer

Interface
REQ-001 Parameter: OFFSET_MAX, default 4095, meaning the largest copy offset allowed (12-bit).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin one block; sampled only in IDLE.
REQ-005 block_len  in  16  block byte count; captured with start.
REQ-006 pos  out  16  current input position, driven to history buffer and hash unit.
REQ-007 tbl_rd_en  out  1  hash-table read strobe for the bucket at pos.
REQ-008 tbl_rd_data  in  16  previous position stored in the bucket; valid one cycle after tbl_rd_en.
REQ-009 tbl_rd_hit  in  1  bucket-valid bit; same timing as tbl_rd_data.
REQ-010 tbl_wr_en  out  1  write pos into the bucket; pulses together with tbl_rd_en.
REQ-011 cmp_ctrl  out  1  ControlBit to the comparator.
REQ-012 cmp_offset  out  12  pos minus tbl_rd_data, to the history buffer.
REQ-013 cmp_length  in  4  comparator match length; combinational from cmp_ctrl/cmp_offset.
REQ-014 item_valid / item_ready  out / in  1 / 1  item handshake.
REQ-015 item_is_copy  out  1  1 = copy item, 0 = literal.
REQ-016 item_offset  out  12  copy offset; 0 for literals.
REQ-017 item_len  out  4  copy length; 0 for literals.
REQ-018 ctrl_valid / ctrl_ready  out / in  1 / 1  control-word handshake.
REQ-019 ctrl_word  out  16  bit i = item_is_copy of item i in the current group.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse when the block completes.

Function
REQ-022 States: IDLE, LOOKUP, COMPARE, EMIT, CTRL, FINISH.
REQ-023 IDLE: start=1 captures block_len and clears pos, group count and ctrl_word; go to LOOKUP if block_len>0, otherwise go to FINISH.
REQ-024 LOOKUP, one cycle: assert tbl_rd_en and tbl_wr_en, then go to COMPARE.
REQ-025 COMPARE, one cycle: offset = pos - tbl_rd_data (16-bit subtraction); cand = tbl_rd_hit AND offset in 1..OFFSET_MAX.
REQ-026 COMPARE: cmp_ctrl = cand and cmp_offset = offset[11:0]; cmp_ctrl is 0 in all other states.
REQ-027 COMPARE: rem = block_len - pos; len = min(cmp_length, rem) when cand, otherwise 0.
REQ-028 COMPARE: len >= 3 registers a copy item (offset, len); otherwise registers a literal item; go to EMIT.
REQ-029 EMIT: hold item_valid=1 with stable fields until item_ready=1.
REQ-030 EMIT handshake: set ctrl_word[group] = item_is_copy, increment group, and advance pos by len (copy) or 1 (literal).
REQ-031 After the EMIT handshake: go to CTRL if group reaches 16 or new pos >= block_len; otherwise go to LOOKUP.
REQ-032 CTRL: hold ctrl_valid=1 and ctrl_word until ctrl_ready=1.
REQ-033 CTRL handshake: clear ctrl_word and group; go to FINISH if pos >= block_len, otherwise go to LOOKUP.
REQ-034 FINISH: pulse done for exactly one cycle, then go to IDLE.
REQ-035 Unused ctrl_word bits in a partial final group are 0.
REQ-036 A block of length 0 emits no items and no control word.
REQ-037 start outside IDLE is ignored; block_len is not re-sampled mid-block.
REQ-038 pos never exceeds block_len, because copy length is clamped to rem.
REQ-039 item_valid and ctrl_valid are never high in the same cycle.
REQ-040 Minimum per-item latency from entering LOOKUP to item_valid is 2 cycles.

Reset
REQ-041 reset=1 at any clock edge forces IDLE from any state, including EMIT and CTRL mid-handshake.
REQ-042 Reset clears to 0: pos, group, ctrl_word, item fields, and all valid/strobe outputs (item_valid, ctrl_valid, tbl_rd_en, tbl_wr_en, cmp_ctrl, busy, done).
REQ-043 A start asserted during reset is ignored.

Verification
REQ-044 block_len=4, tbl_rd_hit always 0, item_ready=1 -> 4 literals at pos 0..3; ctrl_word=0x0000; done pulses once.
REQ-045 block_len=20, hit at pos 4 with tbl_rd_data=0, cmp_length=10 -> copy (offset 4, len 10) as item 4; pos jumps to 14.
REQ-046 block_len=10, pos=8 candidate with cmp_length=15 -> len clamped to 2, so a literal is emitted; ending pos=10.
REQ-047 block_len=40, all literals -> control words after items 16 and 32, plus a final word after item 40 with bits 8..15 = 0.
REQ-048 Offset 4096 with hit=1 -> cmp_ctrl=0 and a literal is emitted; tbl_rd_data=pos (offset 0) -> literal.
REQ-049 item_ready held low 5 cycles in EMIT, then reset asserted -> item fields stable while stalled; after reset busy=0, item_valid=0, and a new start is accepted.

Source files
------------

// File: rtl/lzrw1_sequencer_if.sv
// Handshake and bus bundle between the LZRW1 sequencer and its hash table, comparator,
// item sink and control-word sink.
interface lzrw1_sequencer_if;
  logic        start;
  logic [15:0] block_len;
  logic [15:0] pos;
  logic        tbl_rd_en;
  logic [15:0] tbl_rd_data;
  logic        tbl_rd_hit;
  logic        tbl_wr_en;
  logic        cmp_ctrl;
  logic [11:0] cmp_offset;
  logic [3:0]  cmp_length;
  logic        item_valid;
  logic        item_ready;
  logic        item_is_copy;
  logic [11:0] item_offset;
  logic [3:0]  item_len;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [15:0] ctrl_word;
  logic        busy;
  logic        done;

  modport master (
    input  start, block_len, tbl_rd_data, tbl_rd_hit, cmp_length, item_ready, ctrl_ready,
    output pos, tbl_rd_en, tbl_wr_en, cmp_ctrl, cmp_offset, item_valid, item_is_copy,
           item_offset, item_len, ctrl_valid, ctrl_word, busy, done
  );

  modport slave (
    output start, block_len, tbl_rd_data, tbl_rd_hit, cmp_length, item_ready, ctrl_ready,
    input  pos, tbl_rd_en, tbl_wr_en, cmp_ctrl, cmp_offset, item_valid, item_is_copy,
           item_offset, item_len, ctrl_valid, ctrl_word, busy, done
  );
endinterface

// File: rtl/lzrw1_sequencer.sv
// LZRW1 block sequencer: walks a block position by position, looks up the hash bucket,
// decides literal vs copy, emits items and packs one control word per group of 16 items.
//
// state   | meaning
// IDLE    | waiting for start
// LOOKUP  | hash-table read and write of the bucket at pos
// COMPARE | bucket data valid; evaluate candidate and register the item
// EMIT    | item_valid held until item_ready
// CTRL    | ctrl_valid held until ctrl_ready
// FINISH  | one-cycle done pulse
module lzrw1_sequencer #(
  parameter int OFFSET_MAX = 4095
) (
  input logic              clk,
  input logic              reset,
  lzrw1_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, EMIT, CTRL, FINISH} state_t;

  localparam logic [15:0] OffsetMax = 16'(OFFSET_MAX);

  state_t      state, stateNext;
  logic [15:0] blockLen, blockLenNext;
  logic [15:0] pos, posNext;
  logic [4:0]  group, groupNext;
  logic [15:0] ctrlWord, ctrlWordNext;
  logic        itemIsCopy, itemIsCopyNext;
  logic [11:0] itemOffset, itemOffsetNext;
  logic [3:0]  itemLen, itemLenNext;

  logic [15:0] offset, rem, cmpLenExt, matchLen, advPos;
  logic [4:0]  groupInc;
  logic        cand;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      blockLen   <= '0;
      pos        <= '0;
      group      <= '0;
      ctrlWord   <= '0;
      itemIsCopy <= 1'b0;
      itemOffset <= '0;
      itemLen    <= '0;
    end else begin
      state      <= stateNext;
      blockLen   <= blockLenNext;
      pos        <= posNext;
      group      <= groupNext;
      ctrlWord   <= ctrlWordNext;
      itemIsCopy <= itemIsCopyNext;
      itemOffset <= itemOffsetNext;
      itemLen    <= itemLenNext;
    end
  end

  always_comb begin
    // Candidate and clamped length are only consumed in COMPARE
    offset    = pos - bus.tbl_rd_data;
    cand      = bus.tbl_rd_hit && (offset != 16'd0) && (offset <= OffsetMax);
    rem       = blockLen - pos;
    cmpLenExt = {12'd0, bus.cmp_length};
    matchLen  = cand ? ((cmpLenExt < rem) ? cmpLenExt : rem) : 16'd0;
    advPos    = pos + (itemIsCopy ? {12'd0, itemLen} : 16'd1);
    groupInc  = group + 5'd1;

    stateNext      = state;
    blockLenNext   = blockLen;
    posNext        = pos;
    groupNext      = group;
    ctrlWordNext   = ctrlWord;
    itemIsCopyNext = itemIsCopy;
    itemOffsetNext = itemOffset;
    itemLenNext    = itemLen;

    case (state)
      IDLE: begin
        if (bus.start) begin
          blockLenNext = bus.block_len;
          posNext      = '0;
          groupNext    = '0;
          ctrlWordNext = '0;
          stateNext    = (bus.block_len != 16'd0) ? LOOKUP : FINISH;
        end
      end
      LOOKUP: stateNext = COMPARE;
      COMPARE: begin
        if (matchLen >= 16'd3) begin
          itemIsCopyNext = 1'b1;
          itemOffsetNext = offset[11:0];
          itemLenNext    = matchLen[3:0];
        end else begin
          itemIsCopyNext = 1'b0;
          itemOffsetNext = '0;
          itemLenNext    = '0;
        end
        stateNext = EMIT;
      end
      EMIT: begin
        if (bus.item_ready) begin
          ctrlWordNext[group[3:0]] = itemIsCopy;
          groupNext = groupInc;
          posNext   = advPos;
          stateNext = ((groupInc == 5'd16) || (advPos >= blockLen)) ? CTRL : LOOKUP;
        end
      end
      CTRL: begin
        if (bus.ctrl_ready) begin
          ctrlWordNext = '0;
          groupNext    = '0;
          stateNext    = (pos >= blockLen) ? FINISH : LOOKUP;
        end
      end
      FINISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.pos          = pos;
  assign bus.tbl_rd_en    = (state == LOOKUP);
  assign bus.tbl_wr_en    = (state == LOOKUP);
  assign bus.cmp_ctrl     = (state == COMPARE) && cand;
  assign bus.cmp_offset   = offset[11:0];
  assign bus.item_valid   = (state == EMIT);
  assign bus.item_is_copy = itemIsCopy;
  assign bus.item_offset  = itemOffset;
  assign bus.item_len     = itemLen;
  assign bus.ctrl_valid   = (state == CTRL);
  assign bus.ctrl_word    = ctrlWord;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == FINISH);

endmodule
